// File: rtl/pool_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pool_pkg
// Purpose  : Shared types and constants for the pooling stage.
//            FSM state encoding, pooling-window encoding, accumulator sizing
//            and a helper that turns a window code into a row/column count.
// Ports    : (package - none)
// Revision : 1.0  initial release
// ============================================================================
package pool_pkg;

  // Group-tracking FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2
  } pool_state_e;

  // pool_window encodings.
  localparam logic [1:0] WIN_1    = 2'b00;
  localparam logic [1:0] WIN_2    = 2'b01;
  localparam logic [1:0] WIN_4    = 2'b10;
  localparam logic [1:0] WIN_RSVD = 2'b11;

  // Default element width and accumulator guard bits. Four guard bits hold
  // the sum of up to 16 elements (4 rows x 4 lanes) without overflow.
  localparam int POOL_DWIDTH = 8;
  localparam int ACC_GUARD   = 4;
  localparam int ACC_WIDTH   = POOL_DWIDTH + ACC_GUARD;

  // Window size W for a window code; the reserved code behaves as W=1.
  function automatic logic [2:0] win_rows(input logic [1:0] win);
    case (win)
      WIN_2:           return 3'd2;
      WIN_4:           return 3'd4;
      WIN_1, WIN_RSVD: return 3'd1;
      default:         return 3'd1;
    endcase
  endfunction

endpackage : pool_pkg
`default_nettype wire

// File: rtl/pool_lane_reduce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pool_lane_reduce
// Purpose  : Horizontal reduction of four adjacent accumulator lanes.
//            A two-level max/sum tree: the first level yields two W=2
//            results (lanes 0/1 and 2/3), the second level combines them
//            into the W=4 result. Averages are an arithmetic right shift by
//            log2(W*W), so they round toward minus infinity.
// Ports    : pool_select  0 = max, 1 = average
//            acc_lanes    four accumulator lanes, lane i at [i*AWIDTH +: AWIDTH]
//            lane_valid   accumulated validity bit for each of the four lanes
//            pair_data    two W=2 results, pair k at [k*DWIDTH +: DWIDTH]
//            pair_valid   validity of each W=2 result
//            quad_data    W=4 result
//            quad_valid   validity of the W=4 result
// Revision : 1.0  initial release
// ============================================================================
module pool_lane_reduce
  import pool_pkg::*;
#(
  parameter int DWIDTH = POOL_DWIDTH,
  parameter int AWIDTH = ACC_WIDTH
) (
  input  logic                  pool_select,
  input  logic [4*AWIDTH-1:0]   acc_lanes,
  input  logic [3:0]            lane_valid,
  output logic [2*DWIDTH-1:0]   pair_data,
  output logic [1:0]            pair_valid,
  output logic [DWIDTH-1:0]     quad_data,
  output logic                  quad_valid
);

  // Two extra bits of headroom for the cross-lane sum.
  localparam int SW         = AWIDTH + 2;
  localparam int PAIR_SHIFT = 2;  // log2(2*2)
  localparam int QUAD_SHIFT = 4;  // log2(4*4)

  logic signed [SW-1:0] ext [4];
  logic signed [SW-1:0] max_lo, max_hi, max_q;
  logic signed [SW-1:0] sum_lo, sum_hi, sum_q;
  logic signed [SW-1:0] avg_lo, avg_hi, avg_q;
  logic signed [SW-1:0] res_lo, res_hi, res_q;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ext[i] = {{2{acc_lanes[i*AWIDTH + AWIDTH - 1]}}, acc_lanes[i*AWIDTH +: AWIDTH]};
    end
  end

  // First level: adjacent pairs.
  assign max_lo = (ext[0] > ext[1]) ? ext[0] : ext[1];
  assign max_hi = (ext[2] > ext[3]) ? ext[2] : ext[3];
  assign sum_lo = ext[0] + ext[1];
  assign sum_hi = ext[2] + ext[3];

  // Second level: combine the pairs.
  assign max_q  = (max_lo > max_hi) ? max_lo : max_hi;
  assign sum_q  = sum_lo + sum_hi;

  assign avg_lo = sum_lo >>> PAIR_SHIFT;
  assign avg_hi = sum_hi >>> PAIR_SHIFT;
  assign avg_q  = sum_q  >>> QUAD_SHIFT;

  assign res_lo = pool_select ? avg_lo : max_lo;
  assign res_hi = pool_select ? avg_hi : max_hi;
  assign res_q  = pool_select ? avg_q  : max_q;

  // A window with any invalid contributor is invalid and outputs zero.
  assign pair_valid[0] = lane_valid[0] & lane_valid[1];
  assign pair_valid[1] = lane_valid[2] & lane_valid[3];
  assign quad_valid    = &lane_valid;

  // The results are in element range, so truncation keeps the value.
  assign pair_data[DWIDTH-1:0]      = pair_valid[0] ? DWIDTH'(res_lo) : '0;
  assign pair_data[2*DWIDTH-1:DWIDTH] = pair_valid[1] ? DWIDTH'(res_hi) : '0;
  assign quad_data                  = quad_valid ? DWIDTH'(res_q) : '0;

endmodule : pool_lane_reduce
`default_nettype wire

// File: rtl/pool_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pool_unit
// Purpose  : WxW max/average pooling of the normalizer's vector stream.
//            Rows come from W consecutive beats, columns from W adjacent
//            lanes; results are compacted into the low output lanes.
//            With pooling disabled (or W=1) beats pass through one register.
// Ports    : clk                 clock, rising edge
//            resetn              asynchronous active-low reset
//            enable_pool         1 = pool, 0 = registered bypass
//            pool_select         0 = max, 1 = average
//            pool_window         00:W=1 01:W=2 10:W=4 11:W=1
//            in_data_available   input beat valid
//            inp_data            input vector, lane i at [i*DWIDTH +: DWIDTH]
//            validity_mask       per-lane valid bits of the beat
//            in_last             last beat of the tile
//            out_data            pooled or bypassed vector
//            out_data_available  one-cycle output strobe
//            out_validity_mask   per-lane valid bits of out_data
//            done_pool           strobe with the tile's final output
// Revision : 1.0  initial release
// ============================================================================
module pool_unit
  import pool_pkg::*;
#(
  parameter int DWIDTH      = POOL_DWIDTH,
  parameter int DESIGN_SIZE = 16,
  parameter int MASK_WIDTH  = DESIGN_SIZE
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          enable_pool,
  input  logic                          pool_select,
  input  logic [1:0]                    pool_window,
  input  logic                          in_data_available,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] inp_data,
  input  logic [MASK_WIDTH-1:0]         validity_mask,
  input  logic                          in_last,
  output logic [DESIGN_SIZE*DWIDTH-1:0] out_data,
  output logic                          out_data_available,
  output logic [MASK_WIDTH-1:0]         out_validity_mask,
  output logic                          done_pool
);

  localparam int AW  = DWIDTH + ACC_GUARD;
  localparam int NQ  = DESIGN_SIZE / 4;
  localparam int NP  = DESIGN_SIZE / 2;
  localparam int VW  = DESIGN_SIZE * DWIDTH;

  pool_state_e          state, state_nxt;
  logic                 first_row;

  logic                 cfg_enable, cfg_select;
  logic [1:0]           cfg_window;
  logic                 eff_enable, eff_select;
  logic [1:0]           eff_window;
  logic [2:0]           eff_rows;
  logic                 pooling, win4, complete;

  logic [2:0]           row_cnt, row_cnt_nxt;
  logic signed [AW-1:0] in_ext  [DESIGN_SIZE];
  logic signed [AW-1:0] acc     [DESIGN_SIZE];
  logic signed [AW-1:0] acc_nxt [DESIGN_SIZE];
  logic [MASK_WIDTH-1:0] mask_acc, mask_nxt;

  logic [NP*DWIDTH-1:0] pair_data_all;
  logic [NP-1:0]        pair_valid_all;
  logic [NQ*DWIDTH-1:0] quad_data_all;
  logic [NQ-1:0]        quad_valid_all;
  logic [VW-1:0]        pool_data;
  logic [MASK_WIDTH-1:0] pool_mask;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. A beat in IDLE or EMIT opens a new group, so
  // back-to-back groups flow without bubbles.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_ACCUM: begin
        if (in_data_available) begin
          state_nxt = complete ? ST_EMIT : ST_ACCUM;
        end
      end
      ST_EMIT: begin
        if (in_data_available) begin
          state_nxt = complete ? ST_EMIT : ST_ACCUM;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. Any beat outside ACCUM is the first row of a group.
  // --------------------------------------------------------------------------
  always_comb begin
    first_row = 1'b1;
    if (state == ST_ACCUM) begin
      first_row = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Effective configuration: live inputs on a group's first beat, the
  // latched copy for the rest of the group.
  // --------------------------------------------------------------------------
  assign eff_enable  = first_row ? enable_pool : cfg_enable;
  assign eff_select  = first_row ? pool_select : cfg_select;
  assign eff_window  = first_row ? pool_window : cfg_window;
  assign eff_rows    = win_rows(eff_window);
  assign pooling     = eff_enable && (eff_rows != 3'd1);
  assign win4        = (eff_rows == 3'd4);

  assign row_cnt_nxt = first_row ? 3'd1 : row_cnt + 3'd1;

  // A group closes on its W-th row or on in_last; bypass closes every beat.
  assign complete    = in_data_available &&
                       (!pooling || in_last || (row_cnt_nxt == eff_rows));

  // --------------------------------------------------------------------------
  // Vertical accumulation. The next-state values feed the reducers directly
  // so the result registers on the edge that takes the closing beat.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < DESIGN_SIZE; i++) begin
      in_ext[i] = {{ACC_GUARD{inp_data[i*DWIDTH + DWIDTH - 1]}}, inp_data[i*DWIDTH +: DWIDTH]};
      if (first_row) begin
        acc_nxt[i] = in_ext[i];
      end else if (eff_select) begin
        acc_nxt[i] = acc[i] + in_ext[i];
      end else begin
        acc_nxt[i] = (in_ext[i] > acc[i]) ? in_ext[i] : acc[i];
      end
    end
    mask_nxt = first_row ? validity_mask : (mask_acc & validity_mask);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DESIGN_SIZE; i++) begin
        acc[i] <= '0;
      end
      mask_acc   <= '0;
      row_cnt    <= '0;
      cfg_enable <= 1'b0;
      cfg_select <= 1'b0;
      cfg_window <= WIN_1;
    end else if (in_data_available) begin
      for (int i = 0; i < DESIGN_SIZE; i++) begin
        acc[i] <= acc_nxt[i];
      end
      mask_acc <= mask_nxt;
      row_cnt  <= row_cnt_nxt;
      if (first_row) begin
        cfg_enable <= enable_pool;
        cfg_select <= pool_select;
        cfg_window <= pool_window;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Horizontal reduction, one tree per group of four lanes.
  // --------------------------------------------------------------------------
  for (genvar q = 0; q < NQ; q++) begin : g_quad
    logic [4*AW-1:0] lanes;
    assign lanes = {acc_nxt[4*q+3], acc_nxt[4*q+2], acc_nxt[4*q+1], acc_nxt[4*q]};

    pool_lane_reduce #(
      .DWIDTH (DWIDTH),
      .AWIDTH (AW)
    ) u_reduce (
      .pool_select (eff_select),
      .acc_lanes   (lanes),
      .lane_valid  (mask_nxt[4*q +: 4]),
      .pair_data   (pair_data_all[q*2*DWIDTH +: 2*DWIDTH]),
      .pair_valid  (pair_valid_all[2*q +: 2]),
      .quad_data   (quad_data_all[q*DWIDTH +: DWIDTH]),
      .quad_valid  (quad_valid_all[q])
    );
  end

  // Compaction: output lane j takes pair j (W=2) or quad j (W=4); lanes
  // beyond DESIGN_SIZE/W are zero and invalid.
  for (genvar j = 0; j < DESIGN_SIZE; j++) begin : g_lane
    if (j < NQ) begin : g_low
      assign pool_data[j*DWIDTH +: DWIDTH] = win4 ? quad_data_all[j*DWIDTH +: DWIDTH]
                                                  : pair_data_all[j*DWIDTH +: DWIDTH];
      assign pool_mask[j] = win4 ? quad_valid_all[j] : pair_valid_all[j];
    end else if (j < NP) begin : g_mid
      assign pool_data[j*DWIDTH +: DWIDTH] = win4 ? '0 : pair_data_all[j*DWIDTH +: DWIDTH];
      assign pool_mask[j] = win4 ? 1'b0 : pair_valid_all[j];
    end else begin : g_high
      assign pool_data[j*DWIDTH +: DWIDTH] = '0;
      assign pool_mask[j] = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_data           <= '0;
      out_validity_mask  <= '0;
      out_data_available <= 1'b0;
      done_pool          <= 1'b0;
    end else begin
      out_data_available <= complete;
      done_pool          <= complete & in_last;
      if (complete) begin
        out_data          <= pooling ? pool_data : inp_data;
        out_validity_mask <= pooling ? pool_mask : validity_mask;
      end
    end
  end

endmodule : pool_unit
`default_nettype wire

// File: tb/tb_pool_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pool_unit
// Purpose  : Self-checking bench for pool_unit: directed cases followed by
//            randomized groups compared against an arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pool_unit;

  localparam int DW = 8;
  localparam int DS = 16;
  localparam int VW = DW * DS;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          enable_pool = 1'b0;
  logic          pool_select = 1'b0;
  logic [1:0]    pool_window = 2'b00;
  logic          in_data_available = 1'b0;
  logic [VW-1:0] inp_data = '0;
  logic [DS-1:0] validity_mask = '0;
  logic          in_last = 1'b0;
  logic [VW-1:0] out_data;
  logic          out_data_available;
  logic [DS-1:0] out_validity_mask;
  logic          done_pool;

  int n_checks;
  int n_errors;

  logic [VW-1:0] g_data [4];
  logic [DS-1:0] g_mask [4];
  logic [VW-1:0] exp_d;
  logic [DS-1:0] exp_m;

  always #5 clk = ~clk;

  pool_unit #(
    .DWIDTH      (DW),
    .DESIGN_SIZE (DS),
    .MASK_WIDTH  (DS)
  ) dut (
    .clk                (clk),
    .resetn             (resetn),
    .enable_pool        (enable_pool),
    .pool_select        (pool_select),
    .pool_window        (pool_window),
    .in_data_available  (in_data_available),
    .inp_data           (inp_data),
    .validity_mask      (validity_mask),
    .in_last            (in_last),
    .out_data           (out_data),
    .out_data_available (out_data_available),
    .out_validity_mask  (out_validity_mask),
    .done_pool          (done_pool)
  );

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, out_data, '0);
    chk({tag, "_mask"}, VW'(out_validity_mask), '0);
    chk({tag, "_avail"}, VW'(out_data_available), '0);
    chk({tag, "_done"}, VW'(done_pool), '0);
  endtask

  // Reference: WxW pooling of the first n rows in g_data/g_mask.
  task automatic model(input bit sel, input int w, input int n);
    int  mx, sm, v, q, d;
    bit  ok;
    exp_d = '0;
    exp_m = '0;
    d = w * w;
    for (int j = 0; j < DS / w; j++) begin
      ok = 1'b1;
      mx = -1000;
      sm = 0;
      for (int r = 0; r < n; r++) begin
        for (int c = 0; c < w; c++) begin
          v  = int'($signed(g_data[r][(j*w + c)*DW +: DW]));
          ok = ok & g_mask[r][j*w + c];
          if (v > mx) mx = v;
          sm = sm + v;
        end
      end
      if (ok) begin
        q = sm / d;
        if ((sm % d != 0) && (sm < 0)) q = q - 1;  // floor division
        exp_d[j*DW +: DW] = sel ? q[DW-1:0] : mx[DW-1:0];
        exp_m[j] = 1'b1;
      end
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      chk("idle_avail", VW'(out_data_available), '0);
    end
  endtask

  // Sends n rows from g_data/g_mask as one pooling group, or as n bypass
  // beats. Configuration on non-first pooled beats is scrambled: it must be
  // ignored until the next group.
  task automatic send_group(input bit en, input bit sel, input logic [1:0] win,
                            input int n, input bit last, input bit gaps);
    int w;
    bit pool;
    bit lst;
    w    = (win == 2'b01) ? 2 : (win == 2'b10) ? 4 : 1;
    pool = en && (w > 1);
    if (pool) model(sel, w, n);
    for (int r = 0; r < n; r++) begin
      lst = last && (r == n - 1);
      if (r == 0 || !pool) begin
        enable_pool = en;
        pool_select = sel;
        pool_window = win;
      end else begin
        enable_pool = 1'($urandom_range(0, 1));
        pool_select = 1'($urandom_range(0, 1));
        pool_window = 2'($urandom_range(0, 3));
      end
      in_data_available = 1'b1;
      inp_data          = g_data[r];
      validity_mask     = g_mask[r];
      in_last           = lst;
      @(posedge clk); #1;
      in_data_available = 1'b0;
      in_last           = 1'b0;
      if (!pool) begin
        chk("byp_avail", VW'(out_data_available), VW'(1));
        chk("byp_data", out_data, g_data[r]);
        chk("byp_mask", VW'(out_validity_mask), VW'(g_mask[r]));
        chk("byp_done", VW'(done_pool), VW'(lst));
      end else if (r == n - 1) begin
        chk("pool_avail", VW'(out_data_available), VW'(1));
        chk("pool_data", out_data, exp_d);
        chk("pool_mask", VW'(out_validity_mask), VW'(exp_m));
        chk("pool_done", VW'(done_pool), VW'(last));
      end else begin
        chk("pool_early_avail", VW'(out_data_available), '0);
        if (gaps && ($urandom_range(0, 1) == 1)) begin
          @(posedge clk); #1;
          chk("pool_gap_avail", VW'(out_data_available), '0);
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  w, n;
    bit  en, sel, last;
    logic [1:0] win;

    n_checks = 0;
    n_errors = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    resetn = 1'b1;
    @(posedge clk); #1;

    // Bypass, all lanes 0x42
    g_data[0] = {16{8'h42}};
    g_mask[0] = 16'hFFFF;
    send_group(1'b0, 1'b0, 2'b00, 1, 1'b0, 1'b0);
    idle(1);

    // Max 2x2: lane i = i, then all 0xF0
    for (int i = 0; i < DS; i++) g_data[0][i*DW +: DW] = 8'(i);
    g_data[1] = {16{8'hF0}};
    g_mask[0] = 16'hFFFF;
    g_mask[1] = 16'hFFFF;
    send_group(1'b1, 1'b0, 2'b01, 2, 1'b0, 1'b0);
    idle(1);

    // Average 4x4 of 0x20, then immediately of 0xFF
    for (int r = 0; r < 4; r++) begin
      g_data[r] = {16{8'h20}};
      g_mask[r] = 16'hFFFF;
    end
    send_group(1'b1, 1'b1, 2'b10, 4, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++) g_data[r] = {16{8'hFF}};
    send_group(1'b1, 1'b1, 2'b10, 4, 1'b0, 1'b0);
    idle(1);

    // Masking: 0x5555 on a one-beat 2x2 max group
    g_data[0] = {$urandom, $urandom, $urandom, $urandom};
    g_mask[0] = 16'h5555;
    send_group(1'b1, 1'b0, 2'b01, 1, 1'b1, 1'b0);

    // Partial 4x4 average: two beats of 0x40 with in_last
    g_data[0] = {16{8'h40}};
    g_data[1] = {16{8'h40}};
    g_mask[0] = 16'hFFFF;
    g_mask[1] = 16'hFFFF;
    send_group(1'b1, 1'b1, 2'b10, 2, 1'b1, 1'b0);
    idle(1);

    // Reset in the middle of a 4-beat group
    g_data[0] = {16{8'h5A}};
    g_mask[0] = 16'hFFFF;
    send_group(1'b0, 1'b0, 2'b00, 1, 1'b0, 1'b0);
    enable_pool       = 1'b1;
    pool_select       = 1'b1;
    pool_window       = 2'b10;
    inp_data          = {16{8'h7F}};
    validity_mask     = 16'hFFFF;
    in_data_available = 1'b1;
    @(posedge clk); #1;
    in_data_available = 1'b0;
    chk("rst_pre_avail", VW'(out_data_available), '0);
    #2;
    resetn = 1'b0;
    #1;
    chk_zero("rst_async");
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int r = 0; r < 4; r++) begin
      g_data[r] = {$urandom, $urandom, $urandom, $urandom};
      g_mask[r] = 16'hFFFF;
    end
    send_group(1'b1, 1'b1, 2'b10, 4, 1'b0, 1'b0);
    idle(2);

    // Randomized groups, back-to-back or with short gaps
    for (int g = 0; g < 300; g++) begin
      en  = ($urandom_range(0, 3) != 0);
      sel = 1'($urandom_range(0, 1));
      win = 2'($urandom_range(0, 3));
      w   = (win == 2'b01) ? 2 : (win == 2'b10) ? 4 : 1;
      if (en && w > 1) begin
        n    = int'($urandom_range(1, w));
        last = (n < w) ? 1'b1 : 1'($urandom_range(0, 1));
      end else begin
        n    = int'($urandom_range(1, 3));
        last = 1'($urandom_range(0, 1));
      end
      for (int r = 0; r < 4; r++) begin
        g_data[r] = {$urandom, $urandom, $urandom, $urandom};
        g_mask[r] = ($urandom_range(0, 3) == 0) ? 16'($urandom | $urandom) : 16'hFFFF;
      end
      send_group(en, sel, win, n, last, 1'b1);
      idle(int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pool_unit
`default_nettype wire

// File: doc/pool_unit.md
Name: pool_unit

Overview:
- Pooling stage directly downstream of the normalization block in the TPU post-processing chain (norm -> pool -> activation).
- Consumes the normalizer's vector stream (data, data-available strobe, validity mask) and applies W×W max or average pooling.
- W rows come from W consecutive input beats and W columns from W adjacent lanes. Results are compacted into the low lanes.
- Bypass mode passes vectors through with one cycle of latency.

Parameters:
- DWIDTH, 8, element width, signed two's complement.
- DESIGN_SIZE, 16, lanes per vector.
- MASK_WIDTH, 16, validity mask width; one bit per lane, equal to DESIGN_SIZE.

Ports:
- clk  in  1  single clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- enable_pool  in  1  1 = pool, 0 = registered bypass.
- pool_select  in  1  0 = max, 1 = average.
- pool_window  in  2  00: W=1, 01: W=2, 10: W=4, 11: reserved, treated as W=1.
- in_data_available  in  1  input beat valid this cycle.
- inp_data  in  DESIGN_SIZE*DWIDTH  input vector; lane i at [i*DWIDTH +: DWIDTH].
- validity_mask  in  MASK_WIDTH  per-lane valid bits for the beat.
- in_last  in  1  marks the last beat of the tile; qualified by in_data_available.
- out_data  out  DESIGN_SIZE*DWIDTH  pooled or bypassed vector.
- out_data_available  out  1  one-cycle pulse, out_data valid.
- out_validity_mask  out  MASK_WIDTH  per-lane valid bits of out_data.
- done_pool  out  1  one-cycle pulse coincident with the tile's final output.

Behaviour:
- Reset (resetn=0, asynchronous): FSM to IDLE; row counter, accumulators, out_data, out_validity_mask, out_data_available and done_pool all cleared to 0.
- Configuration latching: enable_pool, pool_select and pool_window are sampled only on the first beat of a group (FSM in IDLE). Changes mid-group take effect at the next group.
- Bypass (enable_pool=0, or W=1):
  - Output on the cycle after each beat: out_data=inp_data, out_validity_mask=validity_mask, out_data_available=1.
  - done_pool=in_last of that beat.
- FSM states:
  - IDLE: wait for a beat. Load the per-lane accumulators with the beat data, set row_cnt=1 and mask_acc=validity_mask. Go to ACCUM, or go to EMIT if in_last.
  - ACCUM: on each beat, per lane: acc = max(acc, x) for max, or acc += x (sign-extended) for average. mask_acc &= validity_mask; row_cnt++. Go to EMIT when row_cnt reaches W or in_last is seen. No beat means hold state.
  - EMIT: one cycle. Register the results and pulse out_data_available; pulse done_pool if the group contained in_last. Return to IDLE.
- Accepting beats in EMIT:
  - Beats arriving while in EMIT are accepted as the first row of the next group, so there are no bubbles.
  - A beat in EMIT also goes to EMIT again if in_last is set on it and W>1 (a one-beat group).
- Horizontal reduction:
  - Output lane j (j < DESIGN_SIZE/W) reduces accumulator lanes j*W .. j*W+W-1: max of the lanes, or sum of the lanes.
  - Lanes j >= DESIGN_SIZE/W output 0 with mask bit 0.
- Average arithmetic:
  - Accumulator width is DWIDTH+4.
  - Result = sum >>> log2(W*W), arithmetic shift (rounds toward -inf), then truncated to DWIDTH. No saturation is needed, since the mean of in-range values stays in range.
- Validity:
  - out_validity_mask[j] = AND of mask_acc over lanes j*W .. j*W+W-1.
  - A lane with mask bit 0 outputs data 0.
- Partial group (in_last before W rows):
  - Max: uses only the rows received.
  - Average: still divides by W*W, i.e. missing rows count as zero.
- Latency: the output pulse occurs 1 cycle after the beat that completes the group.
- Throughput: one output per W input beats.

Decomposition:
- Shared package pool_pkg:
  - FSM state enum (IDLE, ACCUM, EMIT).
  - Window encoding constants.
  - ACC_WIDTH = DWIDTH+4.
- Sub-module pool_lane_reduce: a W-input max/sum tree followed by the shift. Instantiate it DESIGN_SIZE/4 times, sized for W=4, with unused inputs masked for W=2.

Test Plan:
- Bypass: enable_pool=0, one beat of lanes all 8'h42 with mask FFFF.
  - Next cycle: out_data=all 8'h42, out_validity_mask=FFFF, out_data_available=1.
- Max 2×2: enable=1, select=0, window=01.
  - Beat 1: lane i = i. Beat 2: lane i = 8'hF0 (signed -16).
  - Expect out lanes j=0..7 = 2j+1. Lanes 8..15 = 0. Mask = 00FF.
- Average 4×4: select=1, window=10, four beats of all 8'h20.
  - Expect lanes 0..3 = 8'h20, mask = 000F, pulse 1 cycle after beat 4.
  - Repeat with all 8'hFF (-1): expect 8'hFF.
- Masking: validity_mask=5555 on one beat of a 2×2 max.
  - Expect out_validity_mask=0000 and lanes 0..7 = 0.
- Partial group and done: 4×4 average, two beats of all 8'h40, in_last on beat 2.
  - Expect lanes 0..3 = 8'h20 and done_pool=1 coincident with out_data_available.
- Reset mid-operation: drop resetn after 1 beat of a 4-beat group.
  - Outputs are 0 immediately.
  - After release, a fresh 4-beat group produces exactly one output with no stale contribution.
